crc_scan_ctrl: RTL and testbench

CRC_SCAN_CTRL -- requirements
Module: crc_scan_ctrl

---
 rtl/crc_pkg.sv | 22 ++
 rtl/crc_vld_dly.sv | 43 ++++
 rtl/crc_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_crc_scan_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_pkg
//  Description : Shared state encoding and default widths for the CRC scanner.
//  Revision    : 1.0
// ============================================================================
package crc_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int CRC_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4,
        ST_DONE   = 3'd5
    } crc_state_e;

endpackage
`default_nettype wire

// File: rtl/crc_vld_dly.sv
`default_nettype none
// ============================================================================
//  Module      : crc_vld_dly
//  Description : Fixed-depth valid shift register with synchronous flush.
//  Revision    : 1.0
// ============================================================================
module crc_vld_dly
    import crc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk50m,
    input  logic rst_n,
    input  logic flush,
    input  logic vld_in,
    output logic vld_out
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = '0;
        if (!flush) begin
            sr_d[0] = vld_in;
            for (int i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign vld_out = sr_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/crc_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : crc_scan_ctrl
//  Description : Sequences a memory scan through an external CRC calculator
//                and reports the final CRC, optionally checked against a value.
//  Revision    : 1.0
// ============================================================================
module crc_scan_ctrl
    import crc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CRC_W  = CRC_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic              clk50m,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [CRC_W-1:0]  crc_exp,
    input  logic [CRC_W-1:0]  crc_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              crc_clr,
    output logic              crc_en,
    output logic              busy,
    output logic              done,
    output logic [CRC_W-1:0]  crc_result,
    output logic              crc_ok,
    output logic              len_err
);

    localparam logic [ADDR_W:0] LEN_MAX    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    // Drain covers the RD_LAT delay-line stages plus the crc_in register stage.
    localparam logic [2:0]      DRAIN_LAST = 3'(RD_LAT);

    crc_state_e        state_q,      state_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [ADDR_W:0]   left_q,       left_d;
    logic [2:0]        drain_q,      drain_d;
    logic              mode_q,       mode_d;
    logic [CRC_W-1:0]  crc_exp_q,    crc_exp_d;
    logic [CRC_W-1:0]  crc_result_q, crc_result_d;
    logic              crc_ok_q,     crc_ok_d;
    logic              len_err_q,    len_err_d;
    logic              mem_rd_q,     mem_rd_d;
    logic              crc_clr_q,    crc_clr_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              flush;
    logic              len_ok;

    assign len_ok = (length != '0) && (length <= LEN_MAX);

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        left_d       = left_q;
        drain_d      = drain_q;
        mode_d       = mode_q;
        crc_exp_d    = crc_exp_q;
        crc_result_d = crc_result_q;
        crc_ok_d     = crc_ok_q;
        len_err_d    = 1'b0;
        flush        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (len_ok) begin
                        state_d    = ST_CLEAR;
                        mem_addr_d = base_addr;
                        left_d     = length;
                        mode_d     = mode;
                        crc_exp_d  = crc_exp;
                    end else begin
                        len_err_d  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (left_q == LEN_ONE) begin
                    state_d = ST_DRAIN;
                    drain_d = 3'd0;
                end else begin
                    left_d     = left_q - 1'b1;
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_RESULT;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            ST_RESULT: begin
                state_d      = ST_DONE;
                crc_result_d = crc_in;
                crc_ok_d     = mode_q ? (crc_in == crc_exp_q) : 1'b0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort discards the scan: results from an aborted RESULT cycle are dropped.
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            flush        = 1'b1;
            crc_result_d = crc_result_q;
            crc_ok_d     = crc_ok_q;
        end

        busy_d    = (state_d != ST_IDLE);
        crc_clr_d = (state_d == ST_CLEAR);
        mem_rd_d  = (state_d == ST_ISSUE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mem_addr_q   <= '0;
            left_q       <= '0;
            drain_q      <= 3'd0;
            mode_q       <= 1'b0;
            crc_exp_q    <= '0;
            crc_result_q <= '0;
            crc_ok_q     <= 1'b0;
            len_err_q    <= 1'b0;
            mem_rd_q     <= 1'b0;
            crc_clr_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            left_q       <= left_d;
            drain_q      <= drain_d;
            mode_q       <= mode_d;
            crc_exp_q    <= crc_exp_d;
            crc_result_q <= crc_result_d;
            crc_ok_q     <= crc_ok_d;
            len_err_q    <= len_err_d;
            mem_rd_q     <= mem_rd_d;
            crc_clr_q    <= crc_clr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    crc_vld_dly #(
        .DEPTH   (RD_LAT)
    ) u_vld_dly (
        .clk50m  (clk50m),
        .rst_n   (rst_n),
        .flush   (flush),
        .vld_in  (mem_rd_q),
        .vld_out (crc_en)
    );

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign crc_clr    = crc_clr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign crc_result = crc_result_q;
    assign crc_ok     = crc_ok_q;
    assign len_err    = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_scan_ctrl
//  Description : Directed bench with memory and CRC-16 calculator models.
//  Revision    : 1.0
// ============================================================================
module tb_crc_scan_ctrl;

    localparam int AW  = 10;
    localparam int CW  = 16;
    localparam int LAT = 2;

    logic          clk50m = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic          mode   = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length    = '0;
    logic [CW-1:0] crc_exp   = '0;
    logic [CW-1:0] crc_in    = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, crc_clr, crc_en, busy, done, crc_ok, len_err;
    logic [CW-1:0] crc_result;

    logic [15:0]   mem   [1024];
    logic [15:0]   dpipe [LAT];

    int            total = 0;
    int            bad   = 0;
    int            rd_cnt = 0, en_cnt = 0, done_cnt = 0, addr_bad = 0;
    logic [AW-1:0] exp_addr = '0;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic          md;
        logic          flip;
        logic          lerr;
        int            lat;
        logic          ok;
    } vec_t;

    vec_t vt[8];

    crc_scan_ctrl #(.ADDR_W(AW), .CRC_W(CW), .RD_LAT(LAT)) dut (
        .clk50m     (clk50m),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .base_addr  (base_addr),
        .length     (length),
        .crc_exp    (crc_exp),
        .crc_in     (crc_in),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .crc_clr    (crc_clr),
        .crc_en     (crc_en),
        .busy       (busy),
        .done       (done),
        .crc_result (crc_result),
        .crc_ok     (crc_ok),
        .len_err    (len_err)
    );

    always #10 clk50m = ~clk50m;

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [15:0] ref_crc(input logic [AW-1:0] b, input int n);
        logic [15:0]   c;
        logic [AW-1:0] a;
        c = 16'hFFFF;
        a = b;
        for (int i = 0; i < n; i++) begin
            c = crc_step(c, mem[a]);
            a = a + 1'b1;
        end
        return c;
    endfunction

    // External memory (RD_LAT pipeline) and registered CRC calculator.
    always @(posedge clk50m) begin
        dpipe[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        if (crc_clr)      crc_in <= 16'hFFFF;
        else if (crc_en)  crc_in <= crc_step(crc_in, dpipe[LAT-1]);
    end

    always @(negedge clk50m) begin
        if (mem_rd) begin
            if (mem_addr !== exp_addr) addr_bad++;
            exp_addr = exp_addr + 1'b1;
            rd_cnt++;
        end
        if (crc_en) en_cnt++;
        if (done)   done_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic clr_cnt(input logic [AW-1:0] b);
        exp_addr = b;
        rd_cnt   = 0;
        en_cnt   = 0;
        done_cnt = 0;
        addr_bad = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 3000) begin
            tick();
            lat++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic do_scan(input logic [AW-1:0] b, input logic [AW:0] n, input logic md,
                           input logic [CW-1:0] ce, output int lat);
        base_addr = b;
        length    = n;
        mode      = md;
        crc_exp   = ce;
        clr_cnt(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int            lat;
        logic [15:0]   cexp, exp_res, last_ref, ref_a, ref_b;
        logic          last_ok;

        vt[0] = '{base: 10'd0,    len: 11'd1024, md: 1'b0, flip: 1'b0, lerr: 1'b0, lat: 1029, ok: 1'b0};
        vt[1] = '{base: 10'd1020, len: 11'd8,    md: 1'b0, flip: 1'b0, lerr: 1'b0, lat: 13,   ok: 1'b0};
        vt[2] = '{base: 10'd100,  len: 11'd16,   md: 1'b1, flip: 1'b0, lerr: 1'b0, lat: 21,   ok: 1'b1};
        vt[3] = '{base: 10'd100,  len: 11'd16,   md: 1'b1, flip: 1'b1, lerr: 1'b0, lat: 21,   ok: 1'b0};
        vt[4] = '{base: 10'd5,    len: 11'd1,    md: 1'b1, flip: 1'b0, lerr: 1'b0, lat: 6,    ok: 1'b1};
        vt[5] = '{base: 10'd0,    len: 11'd0,    md: 1'b0, flip: 1'b0, lerr: 1'b1, lat: 0,    ok: 1'b0};
        vt[6] = '{base: 10'd0,    len: 11'd1025, md: 1'b0, flip: 1'b0, lerr: 1'b1, lat: 0,    ok: 1'b0};
        vt[7] = '{base: 10'd1023, len: 11'd1024, md: 1'b1, flip: 1'b0, lerr: 1'b0, lat: 1029, ok: 1'b1};

        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 16'h9E37) ^ 16'h5A5A;
        last_ref = '0;
        last_ok  = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_mem_addr",   {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_rd",     {31'd0, mem_rd},   32'd0);
        chk("rst_crc_clr",    {31'd0, crc_clr},  32'd0);
        chk("rst_crc_en",     {31'd0, crc_en},   32'd0);
        chk("rst_busy",       {31'd0, busy},     32'd0);
        chk("rst_done",       {31'd0, done},     32'd0);
        chk("rst_crc_result", {16'd0, crc_result}, 32'd0);
        chk("rst_crc_ok",     {31'd0, crc_ok},   32'd0);
        chk("rst_len_err",    {31'd0, len_err},  32'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            cexp = ref_crc(vt[v].base, int'(vt[v].len));
            if (vt[v].flip) mem[vt[v].base] = mem[vt[v].base] ^ 16'h0008;
            exp_res = ref_crc(vt[v].base, int'(vt[v].len));
            if (vt[v].lerr) begin
                base_addr = vt[v].base;
                length    = vt[v].len;
                mode      = vt[v].md;
                clr_cnt(vt[v].base);
                start = 1'b1;
                tick();
                start = 1'b0;
                chk($sformatf("v%0d_len_err", v), {31'd0, len_err}, 32'd1);
                chk($sformatf("v%0d_busy", v),    {31'd0, busy},    32'd0);
                tick();
                chk($sformatf("v%0d_len_err_pulse", v), {31'd0, len_err}, 32'd0);
                chk($sformatf("v%0d_busy2", v),   {31'd0, busy},    32'd0);
                chk($sformatf("v%0d_no_rd", v),   rd_cnt, 32'd0);
            end else begin
                do_scan(vt[v].base, vt[v].len, vt[v].md, cexp, lat);
                chk($sformatf("v%0d_latency", v), lat, vt[v].lat);
                chk($sformatf("v%0d_crc_result", v), {16'd0, crc_result}, {16'd0, exp_res});
                chk($sformatf("v%0d_crc_ok", v), {31'd0, crc_ok}, {31'd0, vt[v].ok});
                tick();
                chk($sformatf("v%0d_done_pulse", v), {31'd0, done}, 32'd0);
                chk($sformatf("v%0d_idle", v), {31'd0, busy}, 32'd0);
                chk($sformatf("v%0d_rd_cnt", v), rd_cnt, int'(vt[v].len));
                chk($sformatf("v%0d_en_cnt", v), en_cnt, int'(vt[v].len));
                chk($sformatf("v%0d_addr_bad", v), addr_bad, 32'd0);
                chk($sformatf("v%0d_done_cnt", v), done_cnt, 32'd1);
                last_ref = exp_res;
                last_ok  = vt[v].ok;
            end
            if (vt[v].flip) mem[vt[v].base] = mem[vt[v].base] ^ 16'h0008;
        end

        // Abort in the fifth ISSUE cycle
        base_addr = 10'd50;
        length    = 11'd20;
        mode      = 1'b0;
        clr_cnt(10'd50);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("abort_pre_rd", {31'd0, mem_rd}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy",   {31'd0, busy},   32'd0);
        chk("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("abort_crc_en", {31'd0, crc_en}, 32'd0);
        chk("abort_rd_cnt", rd_cnt, 32'd5);
        repeat (30) tick();
        chk("abort_en_cnt",   en_cnt,   32'd3);
        chk("abort_no_done",  done_cnt, 32'd0);
        chk("abort_result",   {16'd0, crc_result}, {16'd0, last_ref});
        chk("abort_ok",       {31'd0, crc_ok},     {31'd0, last_ok});

        // Abort and start together in IDLE
        base_addr = 10'd0;
        length    = 11'd4;
        clr_cnt(10'd0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        chk("abort_start_no_rd", rd_cnt, 32'd0);

        // Back-to-back scans, second start raised during DONE
        ref_a = ref_crc(10'd200, 10);
        ref_b = ref_crc(10'd300, 12);
        do_scan(10'd200, 11'd10, 1'b1, ref_a, lat);
        chk("b2b_a_latency", lat, 32'd15);
        chk("b2b_a_result", {16'd0, crc_result}, {16'd0, ref_a});
        chk("b2b_a_ok", {31'd0, crc_ok}, 32'd1);
        base_addr = 10'd300;
        length    = 11'd12;
        mode      = 1'b0;
        start     = 1'b1;
        tick();
        clr_cnt(10'd300);
        chk("b2b_gap_idle", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0;
        chk("b2b_b_started", {31'd0, crc_clr}, 32'd1);
        wait_done(lat);
        chk("b2b_b_latency", lat, 32'd17);
        chk("b2b_b_result", {16'd0, crc_result}, {16'd0, ref_b});
        chk("b2b_b_ok", {31'd0, crc_ok}, 32'd0);
        chk("b2b_b_rd_cnt", rd_cnt, 32'd12);
        chk("b2b_b_addr_bad", addr_bad, 32'd0);
        tick();

        // Reset mid-scan clears results too
        do_scan(10'd7, 11'd3, 1'b1, ref_crc(10'd7, 3), lat);
        chk("pre_rst_ok", {31'd0, crc_ok}, 32'd1);
        tick();
        base_addr = 10'd0;
        length    = 11'd40;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy",   {31'd0, busy},   32'd0);
        chk("mid_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("mid_rst_crc_en", {31'd0, crc_en}, 32'd0);
        chk("mid_rst_result", {16'd0, crc_result}, 32'd0);
        chk("mid_rst_ok",     {31'd0, crc_ok}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("mid_rst_stay_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
